// File: rtl/ttc_prescaler_lite12.sv
//==============================================================================
// ttc_prescaler_lite12 : TTC count-enable prescaler, pclk or synchronised ext tick
// Optional: TTC_EXT_FILTER_EN adds a 3-sample glitch filter on ext_clk12
// Revision: 1.0
//==============================================================================
`default_nettype none

module ttc_prescaler_lite12 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        pclk12,
  input  logic        p_reset12,
  input  logic        count_en12,
  input  logic [6:0]  clk_ctrl_reg12,
  input  logic        ext_clk12,
  output logic        count_pulse12,
  output logic [15:0] ps_count12
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            ps_count_q, ps_count_d;
  logic                   count_pulse_q, count_pulse_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   ext_tick_q, ext_tick_d;
  logic                   sync_out;
  logic                   level_cur;
  logic                   src_tick;
  logic [15:0]            term;

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef TTC_EXT_FILTER_EN
  // Two previous sync samples; level only moves when all three agree.
  logic [1:0] filt_hist_q, filt_hist_d;

  always_comb begin
    filt_hist_d = {filt_hist_q[0], sync_out};
    level_cur   = hist_q;
    if ((sync_out == filt_hist_q[0]) && (sync_out == filt_hist_q[1])) begin
      level_cur = sync_out;
    end
  end

  always_ff @(posedge pclk12 or posedge p_reset12) begin
    if (p_reset12) begin
      filt_hist_q <= 2'b00;
    end else begin
      filt_hist_q <= filt_hist_d;
    end
  end
`else
  always_comb begin
    level_cur = sync_out;
  end
`endif

  // hist_q is both the edge-detect history and, with the filter, its held level.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ext_clk12};
    hist_d     = level_cur;
    ext_tick_d = clk_ctrl_reg12[6] ? (~level_cur & hist_q) : (level_cur & ~hist_q);
  end

  assign src_tick = clk_ctrl_reg12[5] ? ext_tick_q : 1'b1;
  assign term     = 16'hFFFF >> (4'd15 - clk_ctrl_reg12[4:1]);

  always_comb begin
    state_d       = state_q;
    ps_count_d    = 16'd0;
    count_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_en12) state_d = ARM;
      end
      ARM: begin
        state_d = count_en12 ? RUN : IDLE;
      end
      RUN: begin
        if (!count_en12) begin
          state_d = IDLE;
        end else if (!clk_ctrl_reg12[0]) begin
          count_pulse_d = src_tick;
        end else if (src_tick) begin
          // >= so a lowered N terminates immediately instead of wrapping.
          if (ps_count_q >= term) begin
            count_pulse_d = 1'b1;
          end else begin
            ps_count_d = ps_count_q + 16'd1;
          end
        end else begin
          ps_count_d = ps_count_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk12 or posedge p_reset12) begin
    if (p_reset12) begin
      state_q       <= IDLE;
      ps_count_q    <= 16'd0;
      count_pulse_q <= 1'b0;
      sync_q        <= '0;
      hist_q        <= 1'b0;
      ext_tick_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ps_count_q    <= ps_count_d;
      count_pulse_q <= count_pulse_d;
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      ext_tick_q    <= ext_tick_d;
    end
  end

  assign count_pulse12 = count_pulse_q;
  assign ps_count12    = ps_count_q;

endmodule

`default_nettype wire
